// File: rtl/parser_sequencer_pkg.sv
// Shared widths, sequencer state encoding and the header-table write bundle.
// Latency: n/a. Backpressure: n/a.
package parser_sequencer_pkg;
    localparam int SQ_FIFO_DEPTH = 4;
    localparam int ADDR_W        = 32;
    localparam int DATA_W        = 32;
    localparam int NUM_HDRS      = 2;
    localparam int NT_SIZE       = 2;

    typedef enum logic [2:0] {
        SQ_IDLE  = 3'd0,
        SQ_CFG   = 3'd1,
        SQ_ISSUE = 3'd2,
        SQ_WAIT  = 3'd3,
        SQ_DROP  = 3'd4
    } sq_state_e;

    typedef struct packed {
        logic [DATA_W-1:0]         hdr_id;
        logic [DATA_W-1:0]         hdr_len;
        logic [DATA_W-1:0]         tag_start;
        logic [DATA_W-1:0]         tag_len;
        logic [DATA_W*NT_SIZE-1:0] next_table;
    } cfg_t;
endpackage

// File: rtl/parser_sequencer_fifo.sv
// Generic synchronous FIFO (pointer + count), head is a direct read of storage.
// Latency: 1 cycle push-to-head. Backpressure: push_rdy low while full, push+pop on full is never attempted.
module parser_sequencer_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    output logic             push_rdy,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        push_rdy = (count_q != FULL_CNT);
        empty    = (count_q == '0);
        head_dat = mem_q[rd_ptr_q];
        do_push  = push_vld && push_rdy;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; count gates every read of it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end
endmodule

// File: rtl/parser_sequencer.sv
// Queues packet addresses, runs the parser start/ready handshake and slots header-table writes into idle gaps.
// Latency: 3 + parser cycles from issue to out_valid_o; 1 cycle cfg accept to mod pulse.
// Backpressure: pkt_ready_o low when queue full; no issue while a result is unaccepted; cfg_ready_o only in IDLE.
module parser_sequencer
    import parser_sequencer_pkg::*;
#(
    parameter int FIFO_DEPTH = SQ_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pkt_valid_i,
    input  logic [ADDR_W-1:0]          pkt_addr_i,
    output logic                       pkt_ready_o,
    input  logic                       cfg_valid_i,
    input  logic [DATA_W-1:0]          cfg_hdr_id_i,
    input  logic [DATA_W-1:0]          cfg_hdr_len_i,
    input  logic [DATA_W-1:0]          cfg_tag_start_i,
    input  logic [DATA_W-1:0]          cfg_tag_len_i,
    input  logic [DATA_W*NT_SIZE-1:0]  cfg_next_table_i,
    output logic                       cfg_ready_o,
    output logic                       ps_start_o,
    output logic [ADDR_W-1:0]          ps_pkt_addr_o,
    input  logic                       ps_ready_i,
    input  logic [DATA_W*NUM_HDRS-1:0] ps_hdrs_i,
    output logic                       ps_mod_start_o,
    output logic [DATA_W-1:0]          ps_mod_hdr_id_o,
    output logic [DATA_W-1:0]          ps_mod_hdr_len_o,
    output logic [DATA_W-1:0]          ps_mod_tag_start_o,
    output logic [DATA_W-1:0]          ps_mod_tag_len_o,
    output logic [DATA_W*NT_SIZE-1:0]  ps_mod_next_table_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [ADDR_W-1:0]          out_pkt_addr_o,
    output logic [DATA_W*NUM_HDRS-1:0] out_hdrs_o,
    output logic [DATA_W-1:0]          pkt_cnt_o
);
    sq_state_e                 state_q, state_d;
    logic                      ps_start_q, ps_start_d;
    logic                      ps_mod_start_q, ps_mod_start_d;
    logic [ADDR_W-1:0]         ps_pkt_addr_q, ps_pkt_addr_d;
    cfg_t                      cfg_q, cfg_d;
    logic                      out_valid_q, out_valid_d;
    logic [ADDR_W-1:0]         out_pkt_addr_q, out_pkt_addr_d;
    logic [DATA_W*NUM_HDRS-1:0] out_hdrs_q, out_hdrs_d;
    logic [DATA_W-1:0]         pkt_cnt_q, pkt_cnt_d;
    logic                      fifo_pop, fifo_empty;
    logic [ADDR_W-1:0]         fifo_head;

    parser_sequencer_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (pkt_valid_i),
        .push_dat (pkt_addr_i),
        .push_rdy (pkt_ready_o),
        .pop      (fifo_pop),
        .head_dat (fifo_head),
        .empty    (fifo_empty)
    );

    always_comb begin
        state_d        = state_q;
        ps_start_d     = ps_start_q;
        ps_mod_start_d = ps_mod_start_q;
        ps_pkt_addr_d  = ps_pkt_addr_q;
        cfg_d          = cfg_q;
        out_valid_d    = out_valid_q;
        out_pkt_addr_d = out_pkt_addr_q;
        out_hdrs_d     = out_hdrs_q;
        pkt_cnt_d      = pkt_cnt_q;
        cfg_ready_o    = 1'b0;
        fifo_pop       = 1'b0;

        if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            SQ_IDLE: begin
                // Config writes win so table updates never starve behind traffic.
                if (cfg_valid_i) begin
                    cfg_ready_o    = 1'b1;
                    cfg_d          = '{cfg_hdr_id_i, cfg_hdr_len_i, cfg_tag_start_i,
                                       cfg_tag_len_i, cfg_next_table_i};
                    ps_mod_start_d = 1'b1;
                    state_d        = SQ_CFG;
                end else if (!fifo_empty && !out_valid_q) begin
                    ps_start_d    = 1'b1;
                    ps_pkt_addr_d = fifo_head;
                    fifo_pop      = 1'b1;
                    state_d       = SQ_ISSUE;
                end
            end
            SQ_CFG: begin
                ps_mod_start_d = 1'b0;
                state_d        = SQ_IDLE;
            end
            // ps_ready_i may still be high from the previous packet here.
            SQ_ISSUE: state_d = SQ_WAIT;
            SQ_WAIT: begin
                if (ps_ready_i) begin
                    out_hdrs_d     = ps_hdrs_i;
                    out_pkt_addr_d = ps_pkt_addr_q;
                    ps_start_d     = 1'b0;
                    state_d        = SQ_DROP;
                end
            end
            SQ_DROP: begin
                out_valid_d = 1'b1;
                pkt_cnt_d   = pkt_cnt_q + DATA_W'(1);
                state_d     = SQ_IDLE;
            end
            default: begin
                ps_start_d     = 1'b0;
                ps_mod_start_d = 1'b0;
                state_d        = SQ_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= SQ_IDLE;
            ps_start_q     <= 1'b0;
            ps_mod_start_q <= 1'b0;
            ps_pkt_addr_q  <= '0;
            cfg_q          <= '0;
            out_valid_q    <= 1'b0;
            out_pkt_addr_q <= '0;
            out_hdrs_q     <= '0;
            pkt_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            ps_start_q     <= ps_start_d;
            ps_mod_start_q <= ps_mod_start_d;
            ps_pkt_addr_q  <= ps_pkt_addr_d;
            cfg_q          <= cfg_d;
            out_valid_q    <= out_valid_d;
            out_pkt_addr_q <= out_pkt_addr_d;
            out_hdrs_q     <= out_hdrs_d;
            pkt_cnt_q      <= pkt_cnt_d;
        end
    end

    assign ps_start_o          = ps_start_q;
    assign ps_mod_start_o      = ps_mod_start_q;
    assign ps_pkt_addr_o       = ps_pkt_addr_q;
    assign ps_mod_hdr_id_o     = cfg_q.hdr_id;
    assign ps_mod_hdr_len_o    = cfg_q.hdr_len;
    assign ps_mod_tag_start_o  = cfg_q.tag_start;
    assign ps_mod_tag_len_o    = cfg_q.tag_len;
    assign ps_mod_next_table_o = cfg_q.next_table;
    assign out_valid_o         = out_valid_q;
    assign out_pkt_addr_o      = out_pkt_addr_q;
    assign out_hdrs_o          = out_hdrs_q;
    assign pkt_cnt_o           = pkt_cnt_q;
endmodule
